// File: rtl/tft_frame_decoder.sv
// Loopback monitor for the TFT pixel stream: rebuilds active coordinates, checks
// line/frame geometry and decodes the Gomoku board sampled at every grid intersection.
module tft_frame_decoder #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 480,
   parameter int GRID     = 10,
   parameter int PITCH    = 40,
   parameter int X0       = 245,
   parameter int Y0       = 65
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     den,
   input  logic                     hsync,
   input  logic                     vsync,
   input  logic [7:0]               R,
   input  logic [7:0]               G,
   input  logic [7:0]               B,
   input  logic                     err_clr,
   output logic [GRID*GRID*2-1:0]   board_out,
   output logic [7:0]               cursor_pos,
   output logic                     cursor_seen,
   output logic                     frame_valid,
   output logic [15:0]              frame_count,
   output logic                     line_err,
   output logic                     frame_err
);

   localparam logic [10:0] H_L   = 11'(H_ACTIVE);
   localparam logic [9:0]  V_L   = 10'(V_ACTIVE);
   localparam logic [10:0] X0_L  = 11'(X0);
   localparam logic [9:0]  Y0_L  = 10'(Y0);
   localparam logic [10:0] PX_L  = 11'(PITCH);
   localparam logic [9:0]  PY_L  = 10'(PITCH);
   localparam logic [7:0]  G_L   = 8'(GRID);

   typedef enum logic {S_ARM, S_RUN} state_t;

   state_t                  r_state;
   logic                    r_den_q;
   logic                    r_vs_q;
   logic [10:0]             r_x;
   logic [9:0]              r_y;
   logic [10:0]             r_next_x;
   logic [9:0]              r_next_y;
   logic [7:0]              r_col;
   logic [7:0]              r_row;
   logic [7:0]              r_row_base;
   logic [GRID*GRID*2-1:0]  r_shadow;
   logic [7:0]              r_cidx;
   logic                    r_cflag;
   logic                    r_bad;
   logic [GRID*GRID*2-1:0]  r_board;
   logic [7:0]              r_cursor_pos;
   logic                    r_cursor_seen;
   logic                    r_frame_valid;
   logic [15:0]             r_frame_count;
   logic                    r_line_err;
   logic                    r_frame_err;

   logic                    w_den_fall;
   logic                    w_vs_fall;
   logic                    w_row_hit;
   logic                    w_sample;
   logic                    w_line_bad;
   logic [7:0]              w_cell_idx;
   logic [1:0]              w_code;
   logic                    w_is_cursor;
   logic                    w_unused_hsync;

   assign w_unused_hsync = hsync;
   assign w_den_fall     = r_den_q & ~den;
   assign w_vs_fall      = r_vs_q & ~vsync;
   assign w_row_hit      = (r_y == r_next_y) && (r_row < G_L);
   assign w_sample       = den && w_row_hit && (r_x == r_next_x) && (r_col < G_L);
   assign w_line_bad     = w_den_fall && (r_x != H_L);
   assign w_cell_idx     = r_row_base + r_col;

   always_comb begin
      w_code      = 2'b00;
      w_is_cursor = 1'b0;
      case ({R, G, B})
         24'hFFFFFF: w_code      = 2'b11;
         24'h000000: w_code      = 2'b10;
         24'h0000FF: w_is_cursor = 1'b1;
         default:    w_code      = 2'b00;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_ARM;
         r_den_q       <= 1'b0;
         r_vs_q        <= 1'b0;
         r_x           <= '0;
         r_y           <= '0;
         r_next_x      <= X0_L;
         r_next_y      <= Y0_L;
         r_col         <= '0;
         r_row         <= '0;
         r_row_base    <= '0;
         r_shadow      <= '0;
         r_cidx        <= '0;
         r_cflag       <= 1'b0;
         r_bad         <= 1'b0;
         r_board       <= '0;
         r_cursor_pos  <= '0;
         r_cursor_seen <= 1'b0;
         r_frame_valid <= 1'b0;
         r_frame_count <= '0;
         r_line_err    <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_den_q       <= den;
         r_vs_q        <= vsync;
         r_frame_valid <= 1'b0;

         if (den) r_x <= r_x + 11'd1;
         else     r_x <= '0;

         if (w_den_fall) r_y <= r_y + 10'd1;

         // Incremental intersection trackers replace X0+col*PITCH / Y0+row*PITCH.
         if (w_sample) begin
            r_next_x <= r_next_x + PX_L;
            r_col    <= r_col + 8'd1;
            for (int unsigned k = 0; k < GRID*GRID; k++) begin
               if (w_cell_idx == 8'(k)) r_shadow[2*k +: 2] <= w_code;
            end
            if (w_is_cursor) begin
               r_cidx  <= w_cell_idx;
               r_cflag <= 1'b1;
            end
         end

         if (w_den_fall) begin
            r_next_x <= X0_L;
            r_col    <= '0;
            if (w_row_hit) begin
               r_next_y   <= r_next_y + PY_L;
               r_row      <= r_row + 8'd1;
               r_row_base <= r_row_base + G_L;
            end
         end

         if (w_line_bad) r_bad <= 1'b1;

         if (err_clr) begin
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
         end
         if (w_line_bad) r_line_err <= 1'b1;

         // A line error closing on the vsync-fall cycle still spoils this frame.
         if (w_vs_fall) begin
            if (r_state == S_RUN) begin
               if (r_y != V_L) begin
                  r_frame_err <= 1'b1;
               end else if (!(r_bad || w_line_bad)) begin
                  r_board       <= r_shadow;
                  r_cursor_pos  <= r_cidx;
                  r_cursor_seen <= r_cflag;
                  r_frame_valid <= 1'b1;
                  r_frame_count <= r_frame_count + 16'd1;
               end
            end
            r_state    <= S_RUN;
            r_y        <= '0;
            r_cflag    <= 1'b0;
            r_bad      <= 1'b0;
            r_next_x   <= X0_L;
            r_next_y   <= Y0_L;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
         end
      end
   end

   assign board_out   = r_board;
   assign cursor_pos  = r_cursor_pos;
   assign cursor_seen = r_cursor_seen;
   assign frame_valid = r_frame_valid;
   assign frame_count = r_frame_count;
   assign line_err    = r_line_err;
   assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_tft_frame_decoder.sv
// Randomized pixel-stream bench for tft_frame_decoder, using a reduced panel geometry
// and a cell-level reference model of the published board.
module tb_tft_frame_decoder;

   localparam int H     = 48;
   localparam int V     = 24;
   localparam int GRID  = 4;
   localparam int PITCH = 5;
   localparam int X0    = 6;
   localparam int Y0    = 3;
   localparam int NC    = GRID*GRID;
   localparam int NB    = NC*2;

   logic          clk;
   logic          rst;
   logic          den;
   logic          hsync;
   logic          vsync;
   logic [7:0]    R;
   logic [7:0]    G;
   logic [7:0]    B;
   logic          err_clr;
   logic [NB-1:0] board_out;
   logic [7:0]    cursor_pos;
   logic          cursor_seen;
   logic          frame_valid;
   logic [15:0]   frame_count;
   logic          line_err;
   logic          frame_err;

   tft_frame_decoder #(
      .H_ACTIVE(H), .V_ACTIVE(V), .GRID(GRID), .PITCH(PITCH), .X0(X0), .Y0(Y0)
   ) dut (
      .clk(clk), .rst(rst), .den(den), .hsync(hsync), .vsync(vsync),
      .R(R), .G(G), .B(B), .err_clr(err_clr),
      .board_out(board_out), .cursor_pos(cursor_pos), .cursor_seen(cursor_seen),
      .frame_valid(frame_valid), .frame_count(frame_count),
      .line_err(line_err), .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: board content per cell (0 empty, 1 black, 2 white, 3 cursor).
   int            m_cell [NC];
   logic [1:0]    m_shadow [NC];
   int            m_cidx;
   bit            m_cflag;
   int            m_y;
   bit            m_bad;
   bit            m_synced;
   bit            m_lerr;
   bit            m_ferr;
   logic [NB-1:0] e_board;
   int            e_pos;
   bit            e_seen;
   int            e_count;

   int            n_checks;
   int            n_err;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] other_colour();
      logic [23:0] c;
      c = 24'($urandom);
      if (c == 24'hFFFFFF || c == 24'h000000 || c == 24'h0000FF) c = 24'hD2A050;
      return c;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NC; k++) m_shadow[k] = 2'b00;
      m_cidx = 0; m_cflag = 0; m_y = 0; m_bad = 0; m_synced = 0;
      m_lerr = 0; m_ferr = 0;
      e_board = '0; e_pos = 0; e_seen = 0; e_count = 0;
   endtask

   task automatic new_board();
      int r;
      for (int k = 0; k < NC; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4)       m_cell[k] = 0;
         else if (r < 6)  m_cell[k] = 1;
         else if (r < 9)  m_cell[k] = 2;
         else             m_cell[k] = 3;
      end
   endtask

   task automatic send_line(input int len);
      int nb;
      int k;
      nb = $urandom_range(2, 5);
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         den = 1'b0;
         hsync = (i == 0) ? 1'b0 : 1'b1;
      end
      for (int p = 0; p < len; p++) begin
         @(negedge clk);
         den = 1'b1;
         hsync = 1'b1;
         if (m_y >= Y0 && (m_y - Y0) % PITCH == 0 && (m_y - Y0) / PITCH < GRID &&
             p >= X0 && (p - X0) % PITCH == 0 && (p - X0) / PITCH < GRID) begin
            k = ((m_y - Y0) / PITCH) * GRID + (p - X0) / PITCH;
            case (m_cell[k])
               1: begin {R, G, B} = 24'h000000; m_shadow[k] = 2'b10; end
               2: begin {R, G, B} = 24'hFFFFFF; m_shadow[k] = 2'b11; end
               3: begin {R, G, B} = 24'h0000FF; m_shadow[k] = 2'b00; m_cidx = k; m_cflag = 1; end
               default: begin {R, G, B} = other_colour(); m_shadow[k] = 2'b00; end
            endcase
         end else begin
            {R, G, B} = 24'($urandom);
         end
      end
      @(negedge clk);
      den = 1'b0;
      if (len != H) begin
         m_lerr = 1;
         m_bad  = 1;
      end
      m_y++;
   endtask

   task automatic send_lines(input int n, input int short_at);
      for (int i = 0; i < n; i++) send_line((i == short_at) ? H - 1 : H);
      repeat (3) @(negedge clk);
   endtask

   task automatic do_vsync();
      bit e_valid;
      @(negedge clk);
      den = 1'b0;
      vsync = 1'b0;
      e_valid = 0;
      if (m_synced) begin
         if (m_y != V) begin
            m_ferr = 1;
         end else if (!m_bad) begin
            for (int k = 0; k < NC; k++) e_board[2*k +: 2] = m_shadow[k];
            e_pos   = m_cidx;
            e_seen  = m_cflag;
            e_count = (e_count + 1) % 65536;
            e_valid = 1;
         end
      end
      m_y = 0; m_cflag = 0; m_bad = 0; m_synced = 1;
      @(negedge clk);
      check("frame_valid", frame_valid, e_valid);
      check("board_out", board_out, e_board);
      check("cursor_pos", cursor_pos, e_pos);
      check("cursor_seen", cursor_seen, e_seen);
      check("frame_count", frame_count, e_count);
      check("line_err", line_err, m_lerr);
      check("frame_err", frame_err, m_ferr);
      @(negedge clk);
      check("frame_valid_1cyc", frame_valid, 1'b0);
      @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_errors();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_lerr = 0;
      m_ferr = 0;
      check("line_err_clr", line_err, 1'b0);
      check("frame_err_clr", frame_err, 1'b0);
   endtask

   task automatic check_all_zero();
      check("rst_board", board_out, '0);
      check("rst_cursor_pos", cursor_pos, 0);
      check("rst_cursor_seen", cursor_seen, 0);
      check("rst_frame_valid", frame_valid, 0);
      check("rst_frame_count", frame_count, 0);
      check("rst_line_err", line_err, 0);
      check("rst_frame_err", frame_err, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_err    = 0;
      rst = 1'b1; den = 1'b0; hsync = 1'b1; vsync = 1'b1;
      {R, G, B} = '0; err_clr = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      check_all_zero();
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // First vsync fall only arms; then a board with a cursor in the middle.
      do_vsync();
      for (int k = 0; k < NC; k++) m_cell[k] = 0;
      m_cell[5] = 3;
      send_lines(V, -1);
      do_vsync();

      for (int f = 0; f < 6; f++) begin
         new_board();
         send_lines(V, -1);
         do_vsync();
      end

      // Black at cell 0, white at the last cell, cursor in between.
      for (int k = 0; k < NC; k++) m_cell[k] = 0;
      m_cell[0] = 1; m_cell[NC-1] = 2; m_cell[5] = 3;
      send_lines(V, -1);
      do_vsync();
      check("cell0_black", board_out[1:0], 2'b10);
      check("cell_last_white", board_out[NB-1 -: 2], 2'b11);

      // Shortened line spoils its frame; next clean frame publishes.
      new_board();
      send_lines(V, 7);
      do_vsync();
      new_board();
      send_lines(V, -1);
      do_vsync();
      clear_errors();

      // Truncated frame raises frame_err and leaves the board untouched.
      new_board();
      send_lines(10, -1);
      do_vsync();
      new_board();
      send_lines(V, -1);
      do_vsync();
      clear_errors();

      // Reset mid-frame: outputs clear at once, next vsync only re-arms.
      new_board();
      send_lines(12, -1);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      check_all_zero();
      @(negedge clk);
      rst = 1'b0;
      send_lines(V - 12, -1);
      do_vsync();
      new_board();
      send_lines(V, -1);
      do_vsync();

      // Frame counter wrap.
      @(negedge clk);
      force dut.r_frame_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_count;
      e_count = 65535;
      new_board();
      send_lines(V, -1);
      do_vsync();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/tft_frame_decoder.md
Name: tft_frame_decoder

Overview:
- Receiver-side counterpart of the TFT LCD timing/pixel generator. Consumes the parallel RGB/den/hsync/vsync stream that drives the panel.
- Rebuilds active-pixel coordinates and checks line and frame geometry.
- Samples the rendered Gomoku board at every grid intersection and reconstructs a 10x10 board map plus the cursor position.
- Used as an on-chip loopback monitor and as the bench-side checker for the display path.

Parameters:
- H_ACTIVE, 800, expected den-high pixels per line.
- V_ACTIVE, 480, expected active lines per frame.
- GRID, 10, cells per board side; 100 cells, board_out is GRID*GRID*2 bits.
- PITCH, 40, pixel distance between adjacent grid intersections.
- X0, 245, active-x of the sample point for column 0: intersection + 5 px, off the black grid line.
- Y0, 65, active-y of the sample point for row 0: intersection + 5 px.

Ports:
- clk  in  1  pixel clock, same as panel dclk.
- rst  in  1  reset.
- den  in  1  data enable, active high.
- hsync  in  1  horizontal sync, active low.
- vsync  in  1  vertical sync, active low.
- R, G, B  in  8 each  pixel colour, valid when den=1.
- err_clr  in  1  synchronous clear of the sticky error flags.
- board_out  out  200  decoded board, cell k at bits [2k+1:2k]; 11 white, 10 black, 00 empty.
- cursor_pos  out  8  cell index (row*10+col) where the cursor colour was sampled.
- cursor_seen  out  1  cursor colour found in the last published frame.
- frame_valid  out  1  one-cycle pulse when board_out, cursor_pos and cursor_seen are updated.
- frame_count  out  16  count of published frames, wraps at 65535 to 0.
- line_err  out  1  sticky: a line had a den-high length other than H_ACTIVE.
- frame_err  out  1  sticky: a frame had a line count other than V_ACTIVE.

Behaviour:
- Reset is asynchronous and active-high (rst); clock is clk. On reset:
  - all outputs are 0; internal x=0, y=0, shadow map 0.
  - the synced flag clears: the first vsync fall after reset only arms the decoder, with no publish and no frame check.
- Edge detect: den_q, vsync_q registered every cycle.
  - den fall = den_q & ~den.
  - vsync fall = vsync_q & ~vsync.
  - hsync is monitored only for pulse presence and has no functional effect.
- x counter (11 bit): increments on every den=1 cycle; cleared to 0 on the cycle den is low.
- y counter (10 bit): increments on each den fall; cleared on vsync fall.
- Line check at den fall: if x != H_ACTIVE, line_err <= 1 and the frame is marked bad.
- Sampling:
  - Sample fires when den=1, x == X0+col*PITCH and y == Y0+row*PITCH, for col,row < GRID.
  - Uses incremental next_x/next_y trackers with col/row counters; no multipliers.
  - Colour classification:
    - FFFFFF → 11.
    - 000000 → 10.
    - 0000FF → cursor: shadow cell 00, cursor_idx_shadow <= row*10+col, cursor_flag_shadow <= 1.
    - anything else → 00.
  - Shadow cells written exactly once per frame. Cells never sampled, because the frame was truncated, stay at their value from the previous frame.
- Publish at vsync fall, when synced=1:
  - If y == V_ACTIVE and the frame is not bad: board_out <= shadow, cursor_pos <= cursor_idx_shadow, cursor_seen <= cursor_flag_shadow, frame_valid pulses high for exactly 1 cycle (the cycle after the fall), frame_count++.
  - If y != V_ACTIVE: frame_err <= 1 and there is no publish.
  - If the frame is bad (line_err in this frame): no publish.
  - In all cases: y, cursor_flag_shadow and the bad flag clear; synced <= 1.
- Latency: board_out valid 1 cycle after vsync fall; it holds until the next publish.
- Simultaneous events:
  - den fall on the same cycle as vsync fall: the line check applies first, and its error is counted in the closing frame.
  - err_clr concurrent with a new error: the error wins and the flag stays 1.
- More than one cursor-coloured sample in a frame: the last one (highest index) wins.
- Reset mid-frame: the partial frame is discarded and the decoder re-arms on the next vsync fall.

Test Plan:
- Reset, then 2 clean 800x480 frames from the LCD controller with an empty board → first vsync fall gives no pulse. Second → frame_valid 1 cycle, board_out=0, frame_count=1, cursor_seen=1, cursor_pos=44.
- wood_board with black at 0, white at 99, cursor at 44 → board_out[1:0]=10, [199:198]=11, cursor_pos=44, all other cells 00.
- One line shortened to 799 den cycles → line_err=1, that frame not published (frame_count unchanged); next clean frame publishes. err_clr → line_err=0.
- vsync asserted after 300 lines → frame_err=1, no frame_valid, board_out unchanged.
- rst asserted at line 200 → outputs 0 immediately; next vsync fall only arms; following full frame publishes with frame_count=1.
- Force frame_count to 65535, run a clean frame → frame_count=0, frame_valid pulses.
